// File: rtl/lsq_multi_wb.sv
// Load/store queue: in-order memory ops, wake-up from NUM_WB write-back channels, one request in flight.
// Optional macro LSQ_MMIO_SAFE_EN: loads that target IO space (addr[17:16]==2'b11) wait for ROB head.
module lsq_multi_wb #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ROB_BITS = 4,
  parameter int unsigned NUM_WB   = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       rdy_in,
  input  logic                       flush,
  input  logic                       inst_valid,
  input  logic [3:0]                 inst_type,
  input  logic [ROB_BITS-1:0]        inst_rob_idx,
  input  logic [31:0]                inst_r1,
  input  logic [31:0]                inst_r2,
  input  logic [ROB_BITS-1:0]        inst_dep1,
  input  logic [ROB_BITS-1:0]        inst_dep2,
  input  logic                       inst_has_dep1,
  input  logic                       inst_has_dep2,
  input  logic [11:0]                inst_offset,
  output logic                       full,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*ROB_BITS-1:0] wb_idx,
  input  logic [NUM_WB*32-1:0]       wb_value,
  input  logic                       commit_valid,
  input  logic [ROB_BITS-1:0]        commit_rob_idx,
  output logic                       st_done,
  output logic                       lsb_wb_valid,
  output logic [ROB_BITS-1:0]        lsb_wb_idx,
  output logic [31:0]                lsb_wb_value,
  output logic                       mem_valid,
  output logic                       mem_wr,
  output logic [1:0]                 mem_len,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic                       mem_done,
  input  logic [31:0]                mem_rdata
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NCH   = NUM_WB + 1;

  typedef struct packed {
    logic                valid;
    logic                st;
    logic                uns;
    logic [1:0]          len;
    logic [ROB_BITS-1:0] rob;
    logic [31:0]         r1;
    logic [31:0]         r2;
    logic [ROB_BITS-1:0] dep1;
    logic [ROB_BITS-1:0] dep2;
    logic                has1;
    logic                has2;
    logic [11:0]         off;
  } ent_t;

  typedef enum logic {IDLE, BUSY} state_t;

  ent_t                ent_q [DEPTH];
  ent_t                ent_d [DEPTH];
  ent_t                new_e;
  ent_t                head_e;
  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                full_q, full_d;
  state_t              state_q, state_d;
  logic                pend_q, pend_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                if_wr_q, if_wr_d, if_uns_q, if_uns_d, if_kill_q, if_kill_d;
  logic [1:0]          if_len_q, if_len_d;
  logic [ROB_BITS-1:0] if_rob_q, if_rob_d;
  logic                mem_valid_q, mem_valid_d;
  logic [31:0]         mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;

  logic                ch_v   [NCH];
  logic [ROB_BITS-1:0] ch_idx [NCH];
  logic [31:0]         ch_val [NCH];
  logic [31:0]         head_addr, ld_raw, ld_ext;
  logic                done_c, launch, push, need_commit, commit_ok;

  function automatic logic [31:0] ext_data(input logic [31:0] d, input logic [1:0] len,
                                           input logic uns);
    case (len)
      2'd0:    ext_data = uns ? {24'd0, d[7:0]} : {{24{d[7]}}, d[7:0]};
      2'd1:    ext_data = uns ? {16'd0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: ext_data = d;
    endcase
  endfunction

  // Completion and launch decisions
  always_comb begin
    head_e      = ent_q[head_q];
    head_addr   = head_e.r1 + {{20{head_e.off[11]}}, head_e.off};
    commit_ok   = commit_valid && (commit_rob_idx == head_e.rob);
`ifdef LSQ_MMIO_SAFE_EN
    need_commit = head_e.st || (head_addr[17:16] == 2'b11);
`else
    need_commit = head_e.st;
`endif
    launch       = rdy_in && !flush && (state_q == IDLE) && head_e.valid &&
                   !head_e.has1 && !head_e.has2 && (!need_commit || commit_ok);
    push         = rdy_in && !flush && inst_valid;
    done_c       = rdy_in && (state_q == BUSY) && (mem_done || pend_q);
    ld_raw       = pend_q ? rdata_q : mem_rdata;
    ld_ext       = ext_data(ld_raw, if_len_q, if_uns_q);
    lsb_wb_valid = done_c && !if_wr_q && !if_kill_q;
    lsb_wb_idx   = if_rob_q;
    lsb_wb_value = lsb_wb_valid ? ld_ext : 32'd0;
    st_done      = done_c && if_wr_q;
  end

  // Snooped channels plus own load result as the highest-index channel
  always_comb begin
    for (int k = 0; k < int'(NUM_WB); k++) begin
      ch_v[k]   = wb_valid[k];
      ch_idx[k] = wb_idx[k*ROB_BITS +: ROB_BITS];
      ch_val[k] = wb_value[k*32 +: 32];
    end
    ch_v[NUM_WB]   = lsb_wb_valid;
    ch_idx[NUM_WB] = if_rob_q;
    ch_val[NUM_WB] = lsb_wb_value;
  end

  // Entry array: wake-up, pop, push with bypass, flush; descending scan lets channel 0 win
  always_comb begin
    new_e = '{valid: 1'b1, st: inst_type[3], uns: inst_type[2], len: inst_type[1:0],
              rob: inst_rob_idx, r1: inst_r1, r2: inst_r2, dep1: inst_dep1, dep2: inst_dep2,
              has1: inst_has_dep1, has2: inst_has_dep2, off: inst_offset};
    for (int k = int'(NCH) - 1; k >= 0; k--) begin
      if (inst_has_dep1 && ch_v[k] && (ch_idx[k] == inst_dep1)) begin
        new_e.has1 = 1'b0;
        new_e.r1   = ch_val[k];
      end
      if (inst_has_dep2 && ch_v[k] && (ch_idx[k] == inst_dep2)) begin
        new_e.has2 = 1'b0;
        new_e.r2   = ch_val[k];
      end
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      ent_d[i] = ent_q[i];
      if (rdy_in && ent_q[i].valid) begin
        for (int k = int'(NCH) - 1; k >= 0; k--) begin
          if (ent_q[i].has1 && ch_v[k] && (ch_idx[k] == ent_q[i].dep1)) begin
            ent_d[i].has1 = 1'b0;
            ent_d[i].r1   = ch_val[k];
          end
          if (ent_q[i].has2 && ch_v[k] && (ch_idx[k] == ent_q[i].dep2)) begin
            ent_d[i].has2 = 1'b0;
            ent_d[i].r2   = ch_val[k];
          end
        end
      end
    end
    if (launch) ent_d[head_q].valid = 1'b0;
    if (push)   ent_d[tail_q] = new_e;
    if (rdy_in && flush) begin
      for (int i = 0; i < int'(DEPTH); i++) ent_d[i].valid = 1'b0;
    end
  end

  // Pointers, count and full flag
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    full_d  = full_q;
    if (rdy_in) begin
      if (flush) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        full_d  = 1'b0;
      end else begin
        head_d  = head_q + PTR_W'(launch);
        tail_d  = tail_q + PTR_W'(push);
        count_d = count_q + CNT_W'(push) - CNT_W'(launch);
        full_d  = (count_d == CNT_W'(DEPTH));
      end
    end
  end

  // Request state machine and in-flight register
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    rdata_d     = rdata_q;
    if_wr_d     = if_wr_q;
    if_uns_d    = if_uns_q;
    if_len_d    = if_len_q;
    if_rob_d    = if_rob_q;
    if_kill_d   = if_kill_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (rdy_in) begin
      mem_valid_d = launch;
      if (launch) begin
        state_d     = BUSY;
        if_wr_d     = head_e.st;
        if_uns_d    = head_e.uns;
        if_len_d    = head_e.len;
        if_rob_d    = head_e.rob;
        if_kill_d   = 1'b0;
        mem_addr_d  = head_addr;
        mem_wdata_d = head_e.r2;
      end
      if (done_c) begin
        state_d = IDLE;
        pend_d  = 1'b0;
      end else if (flush && (state_q == BUSY)) begin
        if_kill_d = 1'b1;
      end
    end else if (mem_done && (state_q == BUSY) && !pend_q) begin
      pend_d  = 1'b1;
      rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      rdata_q     <= '0;
      if_wr_q     <= 1'b0;
      if_uns_q    <= 1'b0;
      if_len_q    <= '0;
      if_rob_q    <= '0;
      if_kill_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= ent_d[i];
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      full_q      <= full_d;
      state_q     <= state_d;
      pend_q      <= pend_d;
      rdata_q     <= rdata_d;
      if_wr_q     <= if_wr_d;
      if_uns_q    <= if_uns_d;
      if_len_q    <= if_len_d;
      if_rob_q    <= if_rob_d;
      if_kill_q   <= if_kill_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign full      = full_q;
  assign mem_valid = mem_valid_q;
  assign mem_wr    = if_wr_q;
  assign mem_len   = if_len_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_lsq_multi_wb.sv
// Directed bench for lsq_multi_wb with hand-computed expectations.
module tb_lsq_multi_wb;
  logic        clk = 1'b0;
  logic        rst_n, rdy, flush, inst_valid, inst_has_dep1, inst_has_dep2;
  logic [3:0]  inst_type, inst_rob_idx, inst_dep1, inst_dep2, commit_rob_idx, lsb_wb_idx;
  logic [31:0] inst_r1, inst_r2, mem_rdata, lsb_wb_value, mem_addr, mem_wdata;
  logic [11:0] inst_offset;
  logic [1:0]  wb_valid, mem_len;
  logic [7:0]  wb_idx;
  logic [63:0] wb_value;
  logic        commit_valid, mem_done, full, st_done, lsb_wb_valid, mem_valid, mem_wr;
  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  lsq_multi_wb #(.DEPTH(8), .ROB_BITS(4), .NUM_WB(2)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .flush(flush),
    .inst_valid(inst_valid), .inst_type(inst_type), .inst_rob_idx(inst_rob_idx),
    .inst_r1(inst_r1), .inst_r2(inst_r2), .inst_dep1(inst_dep1), .inst_dep2(inst_dep2),
    .inst_has_dep1(inst_has_dep1), .inst_has_dep2(inst_has_dep2), .inst_offset(inst_offset),
    .full(full), .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_value(wb_value),
    .commit_valid(commit_valid), .commit_rob_idx(commit_rob_idx), .st_done(st_done),
    .lsb_wb_valid(lsb_wb_valid), .lsb_wb_idx(lsb_wb_idx), .lsb_wb_value(lsb_wb_value),
    .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic [3:0] typ, input logic [3:0] rob, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [11:0] off);
    inst_valid    = 1'b1;
    inst_type     = typ;
    inst_rob_idx  = rob;
    inst_r1       = r1;
    inst_r2       = r2;
    inst_offset   = off;
    inst_has_dep1 = 1'b0;
    inst_has_dep2 = 1'b0;
  endtask

  // Pushing into a full queue must never happen
  always @(posedge clk) begin
    if (rst_n && rdy && inst_valid && !flush) begin
      n_assert++;
      assert (!full) else begin
        n_fail++;
        $error("FAIL push_while_full: observed full=%0d expected 0", full);
      end
    end
  end

  initial begin
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; inst_valid = 1'b0; inst_type = '0;
    inst_rob_idx = '0; inst_r1 = '0; inst_r2 = '0; inst_dep1 = '0; inst_dep2 = '0;
    inst_has_dep1 = 1'b0; inst_has_dep2 = 1'b0; inst_offset = '0; wb_valid = '0;
    wb_idx = '0; wb_value = '0; commit_valid = 1'b0; commit_rob_idx = '0;
    mem_done = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_lsb_valid", 32'(lsb_wb_valid), 32'd0);
    chk("rst_st_done", 32'(st_done), 32'd0);
    rst_n = 1'b1;
    tick();

    // lw r1=0x1000 offset -4
    set_inst(4'b0010, 4'd1, 32'h1000, 32'h0, 12'hFFC);
    tick(); inst_valid = 1'b0;
    chk("lw_no_early", 32'(mem_valid), 32'd0);
    tick();
    chk("lw_valid", 32'(mem_valid), 32'd1);
    chk("lw_addr", mem_addr, 32'h0000_0FFC);
    chk("lw_len", 32'(mem_len), 32'd2);
    chk("lw_wr", 32'(mem_wr), 32'd0);
    tick();
    chk("lw_pulse", 32'(mem_valid), 32'd0);
    mem_done = 1'b1; mem_rdata = 32'h8000_0001; #1;
    chk("lw_wb_valid", 32'(lsb_wb_valid), 32'd1);
    chk("lw_wb_value", lsb_wb_value, 32'h8000_0001);
    chk("lw_wb_idx", 32'(lsb_wb_idx), 32'd1);
    tick(); mem_done = 1'b0;
    chk("lw_wb_drop", 32'(lsb_wb_valid), 32'd0);

    // lb then lbu; lbu queued behind lb checks the 2-cycle relaunch
    set_inst(4'b0000, 4'd2, 32'h100, 32'h0, 12'h000);
    tick(); inst_valid = 1'b0;
    tick();
    chk("lb_valid", 32'(mem_valid), 32'd1);
    chk("lb_len", 32'(mem_len), 32'd0);
    set_inst(4'b0100, 4'd3, 32'h104, 32'h0, 12'h000);
    tick(); inst_valid = 1'b0;
    mem_done = 1'b1; mem_rdata = 32'h0000_00F0; #1;
    chk("lb_sext", lsb_wb_value, 32'hFFFF_FFF0);
    chk("lb_idx", 32'(lsb_wb_idx), 32'd2);
    tick(); mem_done = 1'b0;
    chk("relaunch_gap", 32'(mem_valid), 32'd0);
    tick();
    chk("lbu_valid", 32'(mem_valid), 32'd1);
    chk("lbu_addr", mem_addr, 32'h104);
    mem_done = 1'b1; #1;
    chk("lbu_zext", lsb_wb_value, 32'h0000_00F0);
    tick(); mem_done = 1'b0;

    // sw tag 3 waits for commit
    set_inst(4'b1010, 4'd3, 32'h2000, 32'hDEAD_BEEF, 12'h008);
    tick(); inst_valid = 1'b0;
    tick(); tick();
    chk("sw_wait", 32'(mem_valid), 32'd0);
    commit_valid = 1'b1; commit_rob_idx = 4'd2;
    tick(); tick();
    chk("sw_wrong_commit", 32'(mem_valid), 32'd0);
    commit_rob_idx = 4'd3;
    tick(); commit_valid = 1'b0;
    chk("sw_valid", 32'(mem_valid), 32'd1);
    chk("sw_wr", 32'(mem_wr), 32'd1);
    chk("sw_addr", mem_addr, 32'h2008);
    chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    mem_done = 1'b1; #1;
    chk("sw_st_done", 32'(st_done), 32'd1);
    chk("sw_no_lsb", 32'(lsb_wb_valid), 32'd0);
    tick(); mem_done = 1'b0;

    // Issue-cycle bypass from channel 1
    set_inst(4'b0010, 4'd6, 32'h55, 32'h0, 12'h010);
    inst_has_dep1 = 1'b1; inst_dep1 = 4'd5;
    wb_valid = 2'b10; wb_idx = 8'h50; wb_value = {32'h2000, 32'h0};
    tick(); inst_valid = 1'b0; wb_valid = 2'b00;
    tick();
    chk("bypass_valid", 32'(mem_valid), 32'd1);
    chk("bypass_addr", mem_addr, 32'h2010);
    mem_done = 1'b1; tick(); mem_done = 1'b0;

    // Two channels match: channel 0 wins
    set_inst(4'b0010, 4'd7, 32'h0, 32'h0, 12'h000);
    inst_has_dep1 = 1'b1; inst_dep1 = 4'd9;
    tick(); inst_valid = 1'b0;
    tick();
    chk("dep_wait", 32'(mem_valid), 32'd0);
    wb_valid = 2'b11; wb_idx = 8'h99; wb_value = {32'h5000, 32'h4000};
    tick(); wb_valid = 2'b00;
    tick();
    chk("prio_valid", 32'(mem_valid), 32'd1);
    chk("prio_addr", mem_addr, 32'h4000);
    mem_done = 1'b1; tick(); mem_done = 1'b0;

    // Own load result wakes the dependent load behind it
    set_inst(4'b0010, 4'd8, 32'h100, 32'h0, 12'h000);
    tick();
    set_inst(4'b0010, 4'd9, 32'h0, 32'h0, 12'h004);
    inst_has_dep1 = 1'b1; inst_dep1 = 4'd8;
    tick(); inst_valid = 1'b0; inst_has_dep1 = 1'b0;
    chk("fwd_a_addr", mem_addr, 32'h100);
    mem_done = 1'b1; mem_rdata = 32'h3000; #1;
    chk("fwd_a_wb", 32'(lsb_wb_valid), 32'd1);
    tick(); mem_done = 1'b0;
    tick();
    chk("fwd_b_valid", 32'(mem_valid), 32'd1);
    chk("fwd_b_addr", mem_addr, 32'h3004);
    mem_done = 1'b1; tick(); mem_done = 1'b0;

    // Fill all 8 entries with blocked loads, release together, drain
    for (int i = 0; i < 8; i++) begin
      set_inst(4'b0010, 4'(i), 32'h0, 32'h0, 12'(i * 4));
      inst_has_dep1 = 1'b1; inst_dep1 = 4'hF;
      tick();
      if (i == 6) chk("not_full_7", 32'(full), 32'd0);
    end
    inst_valid = 1'b0; inst_has_dep1 = 1'b0;
    chk("full_8", 32'(full), 32'd1);
    wb_valid = 2'b01; wb_idx = 8'h0F; wb_value = {32'h0, 32'h8000};
    tick(); wb_valid = 2'b00;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("drain%0d_valid", i), 32'(mem_valid), 32'd1);
      chk($sformatf("drain%0d_addr", i), mem_addr, 32'h8000 + 32'(i * 4));
      mem_done = 1'b1; #1;
      chk($sformatf("drain%0d_idx", i), 32'(lsb_wb_idx), 32'(i));
      tick(); mem_done = 1'b0;
    end
    chk("drain_full", 32'(full), 32'd0);
    tick(); tick();
    chk("drain_empty", 32'(mem_valid), 32'd0);

    // Flush with in-flight load, queued load and a push in the flush cycle
    set_inst(4'b0010, 4'd1, 32'h600, 32'h0, 12'h000);
    tick(); inst_valid = 1'b0;
    tick();
    chk("fl_valid", 32'(mem_valid), 32'd1);
    set_inst(4'b0010, 4'd2, 32'h610, 32'h0, 12'h000);
    tick();
    set_inst(4'b0010, 4'd3, 32'h620, 32'h0, 12'h000);
    flush = 1'b1;
    tick(); flush = 1'b0; inst_valid = 1'b0;
    mem_done = 1'b1; #1;
    chk("fl_killed", 32'(lsb_wb_valid), 32'd0);
    tick(); mem_done = 1'b0;
    tick(); tick();
    chk("fl_empty", 32'(mem_valid), 32'd0);
    chk("fl_full", 32'(full), 32'd0);
    set_inst(4'b0010, 4'd4, 32'h700, 32'h0, 12'h000);
    tick(); inst_valid = 1'b0;
    tick();
    chk("fl_next_addr", mem_addr, 32'h700);
    mem_done = 1'b1; #1;
    chk("fl_next_wb", 32'(lsb_wb_valid), 32'd1);
    chk("fl_next_idx", 32'(lsb_wb_idx), 32'd4);
    tick(); mem_done = 1'b0;

    // Flush with in-flight store: still completes
    set_inst(4'b1010, 4'd5, 32'h800, 32'h1234, 12'h000);
    tick(); inst_valid = 1'b0;
    commit_valid = 1'b1; commit_rob_idx = 4'd5;
    tick(); commit_valid = 1'b0;
    chk("flst_wr", 32'(mem_wr), 32'd1);
    flush = 1'b1; tick(); flush = 1'b0;
    mem_done = 1'b1; #1;
    chk("flst_st_done", 32'(st_done), 32'd1);
    tick(); mem_done = 1'b0;

    // mem_done during stall is held and processed once rdy returns
    set_inst(4'b0010, 4'd6, 32'h900, 32'h0, 12'h000);
    tick(); inst_valid = 1'b0;
    tick(); tick();
    rdy = 1'b0; mem_done = 1'b1; mem_rdata = 32'h11; #1;
    chk("stall_no_wb", 32'(lsb_wb_valid), 32'd0);
    tick(); mem_done = 1'b0; mem_rdata = 32'h0;
    tick();
    rdy = 1'b1; #1;
    chk("stall_pend_wb", 32'(lsb_wb_valid), 32'd1);
    chk("stall_pend_val", lsb_wb_value, 32'h11);
    tick();
    chk("stall_pend_clr", 32'(lsb_wb_valid), 32'd0);

    // Reset while busy: outstanding mem_done ignored
    set_inst(4'b0010, 4'd7, 32'hA00, 32'h0, 12'h000);
    tick(); inst_valid = 1'b0;
    tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rb_mem_valid", 32'(mem_valid), 32'd0);
    mem_done = 1'b1; #1;
    chk("rb_no_wb", 32'(lsb_wb_valid), 32'd0);
    chk("rb_no_st", 32'(st_done), 32'd0);
    tick(); mem_done = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/lsq_multi_wb.md
Name: lsq_multi_wb

Overview:
- Parametrised next-generation load/store queue sitting between Decoder issue, ROB commit and the memory interface.
- Holds up to DEPTH memory ops in program order and snoops NUM_WB write-back channels for operand wake-up.
- Issues one request at a time to memory from the queue head and returns load data, sign/zero-extended, on its own write-back channel.
- Stores issue only when they are the ROB head; loads issue speculatively.

Parameters:
DEPTH, 8, queue entries; power of two, >=2
ROB_BITS, 4, ROB index width
NUM_WB, 2, number of snooped write-back channels (ALU, LSB, ...)

Ports:
clk_in  in  1  system clock
rst_n_in  in  1  synchronous active-low reset
rdy_in  in  1  global stall; low freezes all state, outputs hold
flush  in  1  ROB mispredict clear
inst_valid  in  1  issue push
inst_type  in  4  [3]=store, [2]=unsigned load, [1:0]=size (0 byte, 1 half, 2 word)
inst_rob_idx  in  ROB_BITS  ROB tag
inst_r1/inst_r2  in  32 each  base / store data
inst_dep1/inst_dep2  in  ROB_BITS each  producer tags
inst_has_dep1/inst_has_dep2  in  1 each  operand pending
inst_offset  in  12  signed offset
full  out  1  registered; queue full next cycle
wb_valid  in  NUM_WB  snooped channel valids
wb_idx  in  NUM_WB*ROB_BITS  channel tags, channel k at [k*ROB_BITS +: ROB_BITS]
wb_value  in  NUM_WB*32  channel values
commit_valid  in  1  ROB head valid
commit_rob_idx  in  ROB_BITS  ROB head tag
st_done  out  1  one-cycle pulse: store finished in memory
lsb_wb_valid  out  1  load result pulse
lsb_wb_idx  out  ROB_BITS  load tag
lsb_wb_value  out  32  extended load data
mem_valid  out  1  registered one-cycle request pulse
mem_wr  out  1  request is store
mem_len  out  2  size code
mem_addr  out  32  r1 + sext(offset), mod 2^32
mem_wdata  out  32  store data
mem_done  in  1  request complete (any later cycle)
mem_rdata  in  32  raw load data, byte-lane 0 aligned

Behaviour:
- Reset (rst_n_in low at posedge): all entries invalid; head=tail=0; count=0; state IDLE; all outputs 0.
- Queue:
  - Circular, head/tail wrap modulo DEPTH; count width clog2(DEPTH)+1.
  - Push at tail on inst_valid. Pop at head on request launch.
  - Push and pop in the same cycle leave count unchanged.
  - full registered = (next count == DEPTH).
  - Push while full is illegal; the bench asserts it never occurs.
- Wake-up:
  - Every cycle, each valid entry with has_depN whose depN matches any valid wb channel captures that value and clears has_depN.
  - Issue-cycle bypass: a pushed operand matching a same-cycle wb is captured at push.
  - Multiple matches: lowest channel index wins.
  - Own lsb_wb output is fed back internally as an extra channel.
- State machine:
  - IDLE -> BUSY when the head entry is valid, has no deps, and:
    - load: unconditionally;
    - store: commit_valid && commit_rob_idx == head tag.
  - On launch: mem_valid=1 next cycle with fields latched into an in-flight register; the entry is popped.
  - BUSY -> IDLE on mem_done.
  - Load done: lsb_wb_valid=1 the same cycle (combinational from mem_done and the in-flight register), value sign- or zero-extended per type.
  - Store done: st_done=1.
  - No new launch is possible in the cycle mem_done arrives; next launch mem_valid comes 2 cycles after mem_done at earliest.
- Flush:
  - Clears all entries, head, tail, count and full next cycle.
  - An in-flight store still completes, with st_done pulsed.
  - An in-flight load is marked killed; its mem_done produces no lsb_wb_valid.
  - A push in the flush cycle is discarded.
- rdy_in low: no push, pop, launch, capture or state change; a mem_done arriving while rdy_in is low is held pending and processed on the first rdy_in-high cycle.
- Reset mid-BUSY: returns to IDLE; any outstanding mem_done is ignored.

Optional Feature:
- Macro LSQ_MMIO_SAFE_EN.
- Defined: a load whose computed address has bits[17:16]==2'b11 (IO space 0x30000+) launches only when it is the ROB head, like stores.
- Undefined: all loads launch speculatively.

Test Plan:
- Load, no deps: push lw r1=0x1000, offset=-4 → mem_valid with addr=0xFFC, len=2. mem_done with rdata=0x80000001 → lsb_wb_valid, value=0x80000001, tag echoed.
- lb sign/zero: rdata=0x000000F0 → lb gives 0xFFFFFFF0; lbu gives 0x000000F0.
- Store waits for commit: push sw tag=3, no deps → mem_valid stays 0 until commit_valid && commit_rob_idx=3. Then mem_wr=1, wdata=r2; mem_done → st_done pulse.
- Wake-up bypass: push a load with dep1=5 in the same cycle as wb channel 1 = (5, 0x2000) → launches with addr 0x2000+offset, no extra wait.
- Full/wrap: push DEPTH loads with mem_done withheld → full=1 after the DEPTH-th push. Drain all → head wraps to 0, count=0, full=0.
- Flush with in-flight load: flush during BUSY → later mem_done gives no lsb_wb_valid; queue empty; next push launches normally.
